// File: rtl/calendar_ctrl.sv
// Calendar sequencer: one-second tick, per-field carry enables with month/leap rules,
// and a shadow-register time-set mode committed via the bank's parallel-load port.
module calendar_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [47:0] cur_time,
  output logic [5:0]  count_enable,
  output logic        load_value_enable,
  output logic [47:0] load_value,
  output logic [4:0]  state
);

  localparam int              CW         = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [47:0]     SHADOW_RST = 48'h00_01_01_00_00_00;

  typedef enum logic [4:0] {
    S_RUN    = 5'd0,
    S_YEAR   = 5'd1,
    S_MON    = 5'd2,
    S_DAY    = 5'd3,
    S_HOUR   = 5'd4,
    S_MIN    = 5'd5,
    S_SEC    = 5'd6,
    S_COMMIT = 5'd7
  } state_t;

  state_t        cur_state, nxt_state;
  logic [CW-1:0] tick_cnt, tick_cnt_nxt;
  logic [47:0]   shadow, shadow_nxt;
  logic [5:0]    ce_nxt, ce_run;
  logic          le_nxt;
  logic [7:0]    day_max;

  // Month and year are BCD; year%4 on BCD digits equals (2*tens + ones)%4.
  function automatic logic [7:0] last_day(input logic [7:0] mon, input logic [7:0] yr);
    logic [3:0] m;
    logic [4:0] y4;
    m  = (mon[7:4] != 4'd0) ? 4'(mon[3:0] + 4'd10) : mon[3:0];
    y4 = 5'({yr[7:4], 1'b0}) + 5'(yr[3:0]);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: last_day = 8'h30;
      4'd2:                    last_day = (y4[1:0] == 2'd0) ? 8'h29 : 8'h28;
      default:                 last_day = 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max,
                                         input logic [7:0] min);
    if (v >= max)              bcd_inc = min;
    else if (v[3:0] == 4'd9)   bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                       bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Carry chain from the live bank digits.
  always_comb begin
    ce_run    = 6'b000000;
    ce_run[0] = 1'b1;
    ce_run[1] = (cur_time[7:0] == 8'h59);
    ce_run[2] = ce_run[1] && (cur_time[15:8] == 8'h59);
    ce_run[3] = ce_run[2] && (cur_time[23:16] == 8'h23);
    ce_run[4] = ce_run[3] && (cur_time[31:24] == last_day(cur_time[39:32], cur_time[47:40]));
    ce_run[5] = ce_run[4] && (cur_time[39:32] == 8'h12);
  end

  always_comb begin
    nxt_state    = cur_state;
    shadow_nxt   = shadow;
    ce_nxt       = 6'b000000;
    le_nxt       = 1'b0;
    day_max      = last_day(shadow[39:32], shadow[47:40]);
    tick_cnt_nxt = (cur_state == S_COMMIT || tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    case (cur_state)
      S_RUN: begin
        // Entering set mode suppresses a coincident tick so the bank holds while editing.
        if (btn_mode) begin
          shadow_nxt = cur_time;
          nxt_state  = S_YEAR;
        end else if (tick_cnt == TICK_LAST) begin
          ce_nxt = ce_run;
        end
      end
      S_COMMIT: nxt_state = S_RUN;
      default: begin
        if (btn_mode) begin
          if (shadow[31:24] > day_max) shadow_nxt[31:24] = day_max;
          nxt_state = state_t'(cur_state + 5'd1);
          le_nxt    = (cur_state == S_SEC);
        end else if (btn_inc) begin
          case (cur_state)
            S_YEAR:  shadow_nxt[47:40] = bcd_inc(shadow[47:40], 8'h99, 8'h00);
            S_MON:   shadow_nxt[39:32] = bcd_inc(shadow[39:32], 8'h12, 8'h01);
            S_DAY:   shadow_nxt[31:24] = bcd_inc(shadow[31:24], day_max, 8'h01);
            S_HOUR:  shadow_nxt[23:16] = bcd_inc(shadow[23:16], 8'h23, 8'h00);
            S_MIN:   shadow_nxt[15:8]  = bcd_inc(shadow[15:8], 8'h59, 8'h00);
            default: shadow_nxt[7:0]   = bcd_inc(shadow[7:0], 8'h59, 8'h00);
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state         <= S_RUN;
      tick_cnt          <= '0;
      shadow            <= SHADOW_RST;
      count_enable      <= 6'b000000;
      load_value_enable <= 1'b0;
    end else begin
      cur_state         <= nxt_state;
      tick_cnt          <= tick_cnt_nxt;
      shadow            <= shadow_nxt;
      count_enable      <= ce_nxt;
      load_value_enable <= le_nxt;
    end
  end

  assign load_value = shadow;
  assign state      = cur_state;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Randomized + directed bench for calendar_ctrl, scored against an integer calendar model.
module tb_calendar_ctrl;
  localparam int TD = 4;
  localparam int W  = 60;

  logic        clk = 1'b0;
  logic        rst_n, btn_mode, btn_inc;
  logic [47:0] cur_time;
  logic [5:0]  count_enable;
  logic        load_value_enable;
  logic [47:0] load_value;
  logic [4:0]  state;

  calendar_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_time(cur_time), .count_enable(count_enable),
    .load_value_enable(load_value_enable), .load_value(load_value), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  // Model: fields as plain integers, index 0 year .. 5 sec.
  int m_state = 0;
  int m_cnt   = 0;
  int sh[6];
  int ct[6];

  function automatic int ld(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] b8(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic logic [47:0] pack6(input int y, input int mo, input int d,
                                        input int h, input int mi, input int s);
    return {b8(y), b8(mo), b8(d), b8(h), b8(mi), b8(s)};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_ct(input int y, input int mo, input int d, input int h, input int mi,
                        input int s);
    ct[0] = y; ct[1] = mo; ct[2] = d; ct[3] = h; ct[4] = mi; ct[5] = s;
  endtask

  task automatic step(input logic r, input logic m, input logic i);
    int old;
    logic [5:0] ce;
    logic le;
    rst_n    = r;
    btn_mode = m;
    btn_inc  = i;
    cur_time = pack6(ct[0], ct[1], ct[2], ct[3], ct[4], ct[5]);
    ce = 6'd0;
    le = 1'b0;
    if (!r) begin
      m_state = 0;
      m_cnt   = 0;
      sh[0] = 0; sh[1] = 1; sh[2] = 1; sh[3] = 0; sh[4] = 0; sh[5] = 0;
    end else begin
      old = m_state;
      if (old == 0) begin
        if (m) begin
          sh = ct;
          m_state = 1;
        end else if (m_cnt == TD - 1) begin
          ce[0] = 1'b1;
          ce[1] = (ct[5] == 59);
          ce[2] = ce[1] && ct[4] == 59;
          ce[3] = ce[2] && ct[3] == 23;
          ce[4] = ce[3] && ct[2] == ld(ct[1], ct[0]);
          ce[5] = ce[4] && ct[1] == 12;
        end
      end else if (old == 7) begin
        m_state = 0;
      end else if (m) begin
        if (sh[2] > ld(sh[1], sh[0])) sh[2] = ld(sh[1], sh[0]);
        le = (old == 6);
        m_state = old + 1;
      end else if (i) begin
        case (old)
          1: sh[0] = (sh[0] + 1) % 100;
          2: sh[1] = sh[1] % 12 + 1;
          3: sh[2] = (sh[2] >= ld(sh[1], sh[0])) ? 1 : sh[2] + 1;
          4: sh[3] = (sh[3] + 1) % 24;
          5: sh[4] = (sh[4] + 1) % 60;
          default: sh[5] = (sh[5] + 1) % 60;
        endcase
      end
      m_cnt = (old == 7) ? 0 : (m_cnt + 1) % TD;
    end
    exp_q.push_back({5'(m_state), ce, le, pack6(sh[0], sh[1], sh[2], sh[3], sh[4], sh[5])});
    @(posedge clk);
    #1;
  endtask

  // Idle until the model's counter is on its last count, then step through the tick.
  task automatic run_to_tick();
    for (int k = 0; k < TD && m_cnt != TD - 1; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expectation registered by the preceding edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", 48'(state), 48'(e[59:55]));
        chk("count_enable", 48'(count_enable), 48'(e[54:49]));
        chk("load_value_enable", 48'(load_value_enable), 48'(e[48]));
        chk("load_value", load_value, e[47:0]);
        chk("ce_le_exclusive", 48'(count_enable != 6'd0 && load_value_enable), 48'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    set_ct(0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_state", 48'(state), 48'd0);
    chk("reset_ce", 48'(count_enable), 48'd0);
    chk("reset_lv", load_value, 48'h00_01_01_00_00_00);
    for (int n = 0; n < 3; n++) begin
      run_to_tick();
      chk("idle_tick", 48'(count_enable), 48'h01);
    end

    set_ct(99, 12, 31, 23, 59, 59); run_to_tick(); chk("rollover", 48'(count_enable), 48'h3f);
    set_ct(24, 2, 28, 23, 59, 59);  run_to_tick(); chk("feb28_leap", 48'(count_enable), 48'h0f);
    set_ct(23, 2, 28, 23, 59, 59);  run_to_tick(); chk("feb28", 48'(count_enable), 48'h1f);
    set_ct(24, 2, 29, 23, 59, 59);  run_to_tick(); chk("feb29_leap", 48'(count_enable), 48'h1f);
    set_ct(23, 4, 30, 23, 59, 59);  run_to_tick(); chk("apr30", 48'(count_enable), 48'h1f);

    set_ct(23, 5, 10, 8, 30, 15);
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) step(1'b1, 1'b1, 1'b0);
    chk("commit_le", 48'(load_value_enable), 48'd1);
    chk("commit_lv", load_value, 48'h26_05_10_08_30_15);
    for (int n = 0; n < 6; n++) step(1'b1, 1'b0, 1'b0);

    set_ct(23, 1, 31, 12, 0, 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) step(1'b1, 1'b1, 1'b0);
    chk("clamp_day", 48'(load_value[31:24]), 48'h28);
    chk("clamp_mon", 48'(load_value[39:32]), 48'h02);
    step(1'b1, 1'b0, 1'b0);

    set_ct(23, 1, 15, 23, 10, 0);
    for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("hour_wrap", 48'(load_value[23:16]), 48'h00);
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    set_ct(23, 5, 10, 8, 30, 15);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("mode_inc_state", 48'(state), 48'd2);
    chk("mode_inc_year", 48'(load_value[47:40]), 48'h23);
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0);
    chk("in_edit_min", 48'(state), 48'd5);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_reset_state", 48'(state), 48'd0);
    chk("mid_reset_le", 48'(load_value_enable), 48'd0);
    chk("mid_reset_lv", load_value, 48'h00_01_01_00_00_00);
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        ct[0] = ($urandom_range(0, 1) == 1) ? 99 : int'($urandom_range(0, 99));
        ct[1] = ($urandom_range(0, 2) == 0) ? 2 : int'($urandom_range(1, 12));
        ct[2] = ($urandom_range(0, 1) == 1) ? ld(ct[1], ct[0]) : int'($urandom_range(1, ld(ct[1], ct[0])));
        ct[3] = ($urandom_range(0, 1) == 1) ? 23 : int'($urandom_range(0, 23));
        ct[4] = ($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 59));
        ct[5] = ($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 59));
      end
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    end
    step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", 48'(exp_q.size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
